// File: rtl/pipe_io_port.sv
// Memory-mapped I/O port on the pipeline MEM stage: two synchronized switch inputs, one output register and a write counter.
// Optional input debouncing is enabled by defining IO_DEBOUNCE_EN.
module pipe_io_port #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_we,
  input  logic        io_re,
  input  logic [7:0]  io_addr,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  output logic        io_rvalid,
  input  logic [3:0]  in_port0,
  input  logic [3:0]  in_port1,
  output logic [31:0] out_port0,
  output logic        in_change
);

  localparam logic [2:0] OFF_IN0    = 3'd0;
  localparam logic [2:0] OFF_IN1    = 3'd1;
  localparam logic [2:0] OFF_OUT0   = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_WCNT   = 3'd4;

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_cfg
    $error("pipe_io_port: DEBOUNCE_CYCLES must lie in 2..65535");
  end

`ifdef IO_DEBOUNCE_EN
  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);
`endif

  logic [3:0] port_raw   [2];
  logic [3:0] stable_val [2];
  logic       stable_chg [2];

  assign port_raw[0] = in_port0;
  assign port_raw[1] = in_port1;

  // Per-input conditioning: 2-flop synchronizer, then optional debounce filter.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [3:0] sync_a_reg;
    logic [3:0] sync_b_reg;

    always_ff @(posedge clock) begin
      if (reset) begin
        sync_a_reg <= '0;
        sync_b_reg <= '0;
      end else begin
        sync_a_reg <= port_raw[gi];
        sync_b_reg <= sync_a_reg;
      end
    end

`ifdef IO_DEBOUNCE_EN
    logic [3:0]  stable_reg, stable_next;
    logic [3:0]  cand_reg, cand_next;
    logic [15:0] cnt_reg, cnt_next;

    // cand_reg is the value being timed; cnt_reg counts its consecutive samples.
    always_comb begin
      stable_next = stable_reg;
      cand_next   = cand_reg;
      cnt_next    = cnt_reg;
      if (sync_b_reg == stable_reg) begin
        cand_next = stable_reg;
        cnt_next  = '0;
      end else if (sync_b_reg != cand_reg) begin
        cand_next = sync_b_reg;
        cnt_next  = 16'd1;
      end else if (cnt_reg == CNT_LAST) begin
        stable_next = sync_b_reg;
        cnt_next    = '0;
      end else begin
        cnt_next = cnt_reg + 16'd1;
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        stable_reg <= '0;
        cand_reg   <= '0;
        cnt_reg    <= '0;
      end else begin
        stable_reg <= stable_next;
        cand_reg   <= cand_next;
        cnt_reg    <= cnt_next;
      end
    end

    assign stable_val[gi] = stable_reg;
    assign stable_chg[gi] = (stable_next != stable_reg);
`else
    assign stable_val[gi] = sync_b_reg;
    assign stable_chg[gi] = (sync_a_reg != sync_b_reg);
`endif
  end

  logic [31:0] out_reg;
  logic [31:0] wcnt_reg;
  logic [1:0]  status_reg, status_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        rvalid_reg;
  logic [31:0] rd_mux;
  logic        addr_hit;
  logic [2:0]  reg_off;
  logic        wr_out;
  logic        rd_status;
  logic        unused_addr_lsb;

  assign addr_hit        = (io_addr[7:5] == 3'b000);
  assign reg_off         = io_addr[4:2];
  assign wr_out          = io_we && addr_hit && (reg_off == OFF_OUT0);
  assign rd_status       = io_re && addr_hit && (reg_off == OFF_STATUS);
  assign unused_addr_lsb = ^io_addr[1:0];

  // Read mux sees pre-edge state, so a same-cycle OUT0 write reads back the old value.
  always_comb begin
    rd_mux = '0;
    if (addr_hit) begin
      case (reg_off)
        OFF_IN0:    rd_mux = {28'd0, stable_val[0]};
        OFF_IN1:    rd_mux = {28'd0, stable_val[1]};
        OFF_OUT0:   rd_mux = out_reg;
        OFF_STATUS: rd_mux = {30'd0, status_reg};
        OFF_WCNT:   rd_mux = wcnt_reg;
        default:    rd_mux = '0;
      endcase
    end
  end

  // A change accepted on the clearing edge wins over the clear.
  always_comb begin
    status_next = rd_status ? 2'b00 : status_reg;
    status_next = status_next | {stable_chg[1], stable_chg[0]};
    rdata_next  = io_re ? rd_mux : rdata_reg;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_reg    <= '0;
      wcnt_reg   <= '0;
      status_reg <= '0;
      rdata_reg  <= '0;
      rvalid_reg <= 1'b0;
    end else begin
      if (wr_out) begin
        out_reg  <= io_wdata;
        wcnt_reg <= wcnt_reg + 32'd1;
      end
      status_reg <= status_next;
      rdata_reg  <= rdata_next;
      rvalid_reg <= io_re;
    end
  end

  assign io_rdata  = rdata_reg;
  assign io_rvalid = rvalid_reg;
  assign out_port0 = out_reg;
  assign in_change = |status_reg;

endmodule

// File: doc/pipe_io_port.md
PIPE_IO_PORT -- requirements
Module: pipe_io_port

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 16; number of consecutive stable clocks required to accept a new input value (legal range 2..65535).
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 io_we  in  1  write strobe from MEM stage (store to I/O space), one word per cycle.
REQ-005 io_re  in  1  read strobe from MEM stage (load from I/O space).
REQ-006 io_addr  in  8  byte address within I/O space; bits [4:2] select the register, bits [1:0] ignored, bits [7:5] must be 0 for a hit.
REQ-007 io_wdata  in  32  store data.
REQ-008 io_rdata  out  32  registered load data.
REQ-009 io_rvalid  out  1  one-cycle pulse qualifying io_rdata.
REQ-010 in_port0, in_port1  in  4 each  asynchronous switch inputs.
REQ-011 out_port0  out  32  output register driving the display block.
REQ-012 in_change  out  1  level; OR of STATUS bits [1:0].

Function
REQ-013 Register map (word offset): 0 IN0 RO = stable in_port0 zero-extended; 1 IN1 RO = stable in_port1 zero-extended; 2 OUT0 RW; 3 STATUS RO (bit0 IN0 changed, bit1 IN1 changed, other bits 0), clear-on-read; 4 WCNT RO = count of accepted OUT0 writes, 32-bit, wraps 0xFFFFFFFF->0.
REQ-014 Read latency exactly 1 clock: io_re at edge N -> io_rdata/io_rvalid valid after edge N+1; io_rvalid low in every other cycle; io_rdata holds its last value when io_rvalid is low.
REQ-015 Reads of unmapped addresses (offsets 5-7 or io_addr[7:5] != 0) return 0 with io_rvalid asserted; writes to them, and writes to RO registers, are ignored.
REQ-016 Write to OUT0 updates out_port0 on the same edge and increments WCNT by 1.
REQ-017 Simultaneous io_re and io_we to OUT0: the read returns the pre-write value and the write takes effect.
REQ-018 Each input passes through a 2-flop synchronizer before any other logic.
REQ-019 A STATUS bit sets on the edge on which its stable input value changes; a STATUS read clears bits [1:0] on the read edge, but a bit that sets on that same edge remains set (set wins).
REQ-020 The read data for STATUS is the value before the clear.
REQ-021 Reading IN0, IN1, OUT0 or WCNT has no side effects.

Reset
REQ-022 While reset is high at an edge: out_port0=0, WCNT=0, STATUS=0, io_rdata=0, io_rvalid=0, synchronizer flops=0, stable values=0, debounce counters=0; any strobe in that cycle is ignored.
REQ-023 Reset mid-debounce discards the pending value; after reset release, an input held non-zero is accepted as a fresh change (STATUS bit sets).

Configuration
REQ-024 Macro IO_DEBOUNCE_EN defined: a per-port counter restarts whenever the synchronized value changes; the stable value updates only after DEBOUNCE_CYCLES consecutive identical synchronized samples that differ from it; total latency input edge -> IN register = DEBOUNCE_CYCLES+2 clocks.
REQ-025 Macro IO_DEBOUNCE_EN undefined: no counters; stable value = synchronizer output, latency 2 clocks; DEBOUNCE_CYCLES unused.

Verification
REQ-026 Reset, then read offsets 0-4 -> all return 0, io_rvalid one pulse per read, out_port0=0.
REQ-027 Write 0xDEADBEEF to 0x08, then read 0x08 and 0x10 -> out_port0=0xDEADBEEF, reads return 0xDEADBEEF and 1; same-cycle read+write of 0x12345678 returns 0xDEADBEEF.
REQ-028 With IO_DEBOUNCE_EN, DEBOUNCE_CYCLES=4: in_port0 0->0xA held -> IN0 reads 0xA from clock 6, STATUS=0x1, in_change=1; glitch 0xA->0x3 for 3 clocks -> IN0 stays 0xA, STATUS unchanged.
REQ-029 Read STATUS=0x1 -> returns 0x1, next read returns 0; in_port1 change accepted on the STATUS read edge -> read returns old value, bit1 remains set afterward.
REQ-030 Preload WCNT to 0xFFFFFFFF via 2^32-1 writes (or force), one more OUT0 write -> WCNT=0; read 0x1C and 0x20 -> 0, writes there do not alter any register.
